issue_scoreboard: RTL and testbench



---
 rtl/issue_scoreboard.sv | 176 +++++++++++++++++
 tb/tb_issue_scoreboard.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - one-entry issue buffer with pending-write scoreboard
// Stalls RAW/WAW hazards on long-latency destinations and serializes CSR/system instructions.
module issue_scoreboard #(
    parameter int MaxPending = 4,
    parameter int CntW       = $clog2(MaxPending + 1)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [4:0]  in_rs1_i,
    input  logic [4:0]  in_rs2_i,
    input  logic [4:0]  in_rd_i,
    input  logic        in_use_rs1_i,
    input  logic        in_use_rs2_i,
    input  logic        in_long_i,
    input  logic        in_serial_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [4:0]  out_rs1_o,
    output logic [4:0]  out_rs2_o,
    output logic [4:0]  out_rd_o,
    output logic        out_long_o,
    output logic        out_serial_o,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_rd_i,
    input  logic        serial_done_i,
    input  logic        flush_i,
    output logic [31:0] pending_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_SERIAL
    } state_e;

    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxPending);

    state_e          state_q, state_d;
    logic            buf_valid_q, buf_valid_d;
    logic [4:0]      buf_rs1_q, buf_rs1_d;
    logic [4:0]      buf_rs2_q, buf_rs2_d;
    logic [4:0]      buf_rd_q, buf_rd_d;
    logic            buf_use_rs1_q, buf_use_rs1_d;
    logic            buf_use_rs2_q, buf_use_rs2_d;
    logic            buf_long_q, buf_long_d;
    logic            buf_serial_q, buf_serial_d;
    logic [31:0]     pending_q, pending_d;
    logic [CntW-1:0] count_q, count_d;

    logic [31:0]     clr;
    logic [31:0]     set;
    logic [31:0]     eff;
    logic            comp;
    logic [CntW-1:0] count_eff;
    logic            hazard;
    logic            issue_ok;
    logic            fire;
    logic            accept;

    always_comb begin
        clr  = '0;
        comp = 1'b0;
        if (wb_valid_i && (wb_rd_i != 5'd0)) begin
            clr  = 32'd1 << wb_rd_i;
            // A writeback for a register that is not pending must not decrement the count.
            comp = pending_q[wb_rd_i];
        end
        eff       = pending_q & ~clr;
        count_eff = count_q - CntW'(comp);

        hazard = (buf_use_rs1_q && eff[buf_rs1_q]) ||
                 (buf_use_rs2_q && eff[buf_rs2_q]) ||
                 (buf_long_q && (buf_rd_q != 5'd0) && eff[buf_rd_q]);

        issue_ok = buf_valid_q && !hazard && (state_q == ST_RUN) &&
                   (!buf_long_q || (count_eff < MaxCnt)) &&
                   (!buf_serial_q || (count_eff == '0));

        out_valid_o = issue_ok && !flush_i;
        fire        = out_valid_o && out_ready_i;
        in_ready_o  = (!buf_valid_q || fire) && !flush_i;
        accept      = in_valid_i && in_ready_o;

        set = '0;
        if (fire && buf_long_q && (buf_rd_q != 5'd0)) begin
            set = 32'd1 << buf_rd_q;
        end
        pending_d = eff | set;
        count_d   = count_eff + CntW'(set != '0);

        buf_valid_d   = buf_valid_q;
        buf_rs1_d     = buf_rs1_q;
        buf_rs2_d     = buf_rs2_q;
        buf_rd_d      = buf_rd_q;
        buf_use_rs1_d = buf_use_rs1_q;
        buf_use_rs2_d = buf_use_rs2_q;
        buf_long_d    = buf_long_q;
        buf_serial_d  = buf_serial_q;
        if (flush_i) begin
            buf_valid_d = 1'b0;
        end else if (accept) begin
            buf_valid_d   = 1'b1;
            buf_rs1_d     = in_rs1_i;
            buf_rs2_d     = in_rs2_i;
            buf_rd_d      = in_rd_i;
            buf_use_rs1_d = in_use_rs1_i;
            buf_use_rs2_d = in_use_rs2_i;
            buf_long_d    = in_long_i;
            buf_serial_d  = in_serial_i;
        end else if (fire) begin
            buf_valid_d = 1'b0;
        end

        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (fire && buf_serial_q) begin
                    state_d = ST_SERIAL;
                end else if (buf_valid_q && buf_serial_q && (count_eff != '0) && !flush_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (flush_i || (count_eff == '0)) begin
                    state_d = ST_RUN;
                end
            end
            ST_SERIAL: begin
                if (serial_done_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_RUN;
            buf_valid_q   <= 1'b0;
            buf_rs1_q     <= '0;
            buf_rs2_q     <= '0;
            buf_rd_q      <= '0;
            buf_use_rs1_q <= 1'b0;
            buf_use_rs2_q <= 1'b0;
            buf_long_q    <= 1'b0;
            buf_serial_q  <= 1'b0;
            pending_q     <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            buf_valid_q   <= buf_valid_d;
            buf_rs1_q     <= buf_rs1_d;
            buf_rs2_q     <= buf_rs2_d;
            buf_rd_q      <= buf_rd_d;
            buf_use_rs1_q <= buf_use_rs1_d;
            buf_use_rs2_q <= buf_use_rs2_d;
            buf_long_q    <= buf_long_d;
            buf_serial_q  <= buf_serial_d;
            pending_q     <= pending_d;
            count_q       <= count_d;
        end
    end

    assign out_rs1_o    = buf_rs1_q;
    assign out_rs2_o    = buf_rs2_q;
    assign out_rd_o     = buf_rd_q;
    assign out_long_o   = buf_long_q;
    assign out_serial_o = buf_serial_q;
    assign pending_o    = pending_q;
    assign busy_o       = (count_q != '0) || (state_q != ST_RUN);

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - directed scenarios plus randomized run against a reference model
module tb_issue_scoreboard;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [4:0]  in_rs1_i, in_rs2_i, in_rd_i;
    logic        in_use_rs1_i, in_use_rs2_i, in_long_i, in_serial_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [4:0]  out_rs1_o, out_rs2_o, out_rd_o;
    logic        out_long_o, out_serial_o;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_i;
    logic        serial_done_i;
    logic        flush_i;
    logic [31:0] pending_o;
    logic        busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    issue_scoreboard #(.MaxPending(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_rd_i(in_rd_i),
        .in_use_rs1_i(in_use_rs1_i), .in_use_rs2_i(in_use_rs2_i),
        .in_long_i(in_long_i), .in_serial_i(in_serial_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_rs1_o(out_rs1_o), .out_rs2_o(out_rs2_o), .out_rd_o(out_rd_o),
        .out_long_o(out_long_o), .out_serial_o(out_serial_o),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
        .serial_done_i(serial_done_i), .flush_i(flush_i),
        .pending_o(pending_o), .busy_o(busy_o)
    );

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, lng, ser;
    } instr_t;

    // Reference model: buffer as a queue, pending set as a bit vector, modes as flags.
    instr_t      m_buf[$];
    logic [31:0] m_pend;
    bit          m_drain, m_ser;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        in_valid_i = 0; in_rs1_i = 0; in_rs2_i = 0; in_rd_i = 0;
        in_use_rs1_i = 0; in_use_rs2_i = 0; in_long_i = 0; in_serial_i = 0;
        wb_valid_i = 0; wb_rd_i = 0; serial_done_i = 0; flush_i = 0;
    endtask

    task automatic put(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic lng, input logic ser);
        in_valid_i = 1; in_rs1_i = rs1; in_rs2_i = rs2; in_rd_i = rd;
        in_use_rs1_i = u1; in_use_rs2_i = u2; in_long_i = lng; in_serial_i = ser;
    endtask

    task automatic do_reset();
        idle();
        out_ready_i = 1;
        rst_i = 1;
        step();
        step();
        rst_i = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (out_valid_o !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); else n_pass++;
        n_checks++; if (in_ready_o !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); else n_pass++;
        n_checks++; if (pending_o !== 32'h0) $display("FAIL reset_pending got=%h exp=0", pending_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_o); else n_pass++;
        n_checks++;
        if ({out_rs1_o, out_rs2_o, out_rd_o, out_long_o, out_serial_o} !== 17'h0)
            $display("FAIL reset_fields got=%h exp=0", {out_rs1_o, out_rs2_o, out_rd_o, out_long_o, out_serial_o});
        else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        put(0, 0, 5, 0, 0, 1, 0);
        step();
        put(5, 1, 6, 1, 1, 0, 0);
        n_checks++; if (out_valid_o !== 1'b1) $display("FAIL lu_load_issue got=%b exp=1", out_valid_o); else n_pass++;
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (out_valid_o !== 1'b0) $display("FAIL lu_stall got=%b exp=0", out_valid_o); else n_pass++;
            step();
        end
        n_checks++; if (pending_o !== 32'h20) $display("FAIL lu_pending_set got=%h exp=20", pending_o); else n_pass++;
        wb_valid_i = 1; wb_rd_i = 5;
        #1;
        n_checks++; if (out_valid_o !== 1'b1) $display("FAIL lu_same_cycle_issue got=%b exp=1", out_valid_o); else n_pass++;
        step();
        idle();
        n_checks++; if (pending_o !== 32'h0) $display("FAIL lu_pending_clr got=%h exp=0", pending_o); else n_pass++;
        n_checks++; if (out_valid_o !== 1'b0) $display("FAIL lu_empty got=%b exp=0", out_valid_o); else n_pass++;
    endtask

    task automatic test_max_pending();
        logic [31:0] exp_pend;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            put(0, 0, 5'(i), 0, 0, 1, 0);
            step();
        end
        put(0, 0, 7, 0, 0, 1, 0);
        step();
        idle();
        exp_pend = 32'h1E;
        n_checks++; if (out_valid_o !== 1'b0) $display("FAIL mp_fifth_stall got=%b exp=0", out_valid_o); else n_pass++;
        n_checks++; if (pending_o !== exp_pend) $display("FAIL mp_pending4 got=%h exp=%h", pending_o, exp_pend); else n_pass++;
        step();
        wb_valid_i = 1; wb_rd_i = 2;
        #1;
        n_checks++; if (out_valid_o !== 1'b1) $display("FAIL mp_fifth_issue got=%b exp=1", out_valid_o); else n_pass++;
        step();
        idle();
        exp_pend = (exp_pend & ~(32'd1 << 2)) | (32'd1 << 7);
        n_checks++; if (pending_o !== exp_pend) $display("FAIL mp_pending_after got=%h exp=%h", pending_o, exp_pend); else n_pass++;
        put(0, 0, 8, 0, 0, 1, 0);
        step();
        idle();
        n_checks++; if (out_valid_o !== 1'b0) $display("FAIL mp_count_full got=%b exp=0", out_valid_o); else n_pass++;
        wb_valid_i = 1; wb_rd_i = 1;
        #1;
        n_checks++; if (out_valid_o !== 1'b1) $display("FAIL mp_sixth_issue got=%b exp=1", out_valid_o); else n_pass++;
        step();
        idle();
    endtask

    task automatic test_serial();
        do_reset();
        put(0, 0, 1, 0, 0, 1, 0); step();
        put(0, 0, 2, 0, 0, 1, 0); step();
        put(0, 0, 3, 0, 0, 1, 1); step();
        idle();
        n_checks++; if (out_valid_o !== 1'b0) $display("FAIL ser_hold got=%b exp=0", out_valid_o); else n_pass++;
        step();
        n_checks++; if (busy_o !== 1'b1) $display("FAIL ser_drain_busy got=%b exp=1", busy_o); else n_pass++;
        wb_valid_i = 1; wb_rd_i = 1; step();
        wb_rd_i = 2; #1;
        n_checks++; if (out_valid_o !== 1'b0) $display("FAIL ser_drain_novalid got=%b exp=0", out_valid_o); else n_pass++;
        step();
        idle();
        put(5, 0, 9, 1, 0, 0, 0);
        n_checks++; if (out_valid_o !== 1'b1) $display("FAIL ser_issue got=%b exp=1", out_valid_o); else n_pass++;
        n_checks++; if (out_serial_o !== 1'b1) $display("FAIL ser_flag got=%b exp=1", out_serial_o); else n_pass++;
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (out_valid_o !== 1'b0) $display("FAIL ser_block got=%b exp=0", out_valid_o); else n_pass++;
            step();
        end
        n_checks++; if (busy_o !== 1'b1) $display("FAIL ser_busy got=%b exp=1", busy_o); else n_pass++;
        serial_done_i = 1; #1;
        n_checks++; if (out_valid_o !== 1'b0) $display("FAIL ser_done_cycle got=%b exp=0", out_valid_o); else n_pass++;
        step();
        idle();
        n_checks++; if (out_valid_o !== 1'b1 || out_rd_o !== 5'd9) $display("FAIL ser_next_issue got=%b/%0d exp=1/9", out_valid_o, out_rd_o); else n_pass++;
        step();
        wb_valid_i = 1; wb_rd_i = 3; step();
        idle();
        n_checks++; if (busy_o !== 1'b0) $display("FAIL ser_idle_busy got=%b exp=0", busy_o); else n_pass++;
    endtask

    task automatic test_x0();
        do_reset();
        put(0, 0, 0, 0, 0, 1, 0); step();
        put(0, 0, 7, 1, 1, 0, 0); step();
        idle();
        n_checks++; if (pending_o !== 32'h0) $display("FAIL x0_pending got=%h exp=0", pending_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL x0_busy got=%b exp=0", busy_o); else n_pass++;
        n_checks++; if (out_valid_o !== 1'b1) $display("FAIL x0_no_stall got=%b exp=1", out_valid_o); else n_pass++;
        step();
    endtask

    task automatic test_flush_wb();
        do_reset();
        put(0, 0, 5, 0, 0, 1, 0); step();
        put(5, 0, 6, 1, 0, 0, 0); step();
        idle();
        n_checks++; if (out_valid_o !== 1'b0) $display("FAIL fl_stalled got=%b exp=0", out_valid_o); else n_pass++;
        flush_i = 1; wb_valid_i = 1; wb_rd_i = 5; in_valid_i = 1; #1;
        n_checks++; if (out_valid_o !== 1'b0) $display("FAIL fl_no_issue got=%b exp=0", out_valid_o); else n_pass++;
        n_checks++; if (in_ready_o !== 1'b0) $display("FAIL fl_no_accept got=%b exp=0", in_ready_o); else n_pass++;
        step();
        idle();
        n_checks++; if (out_valid_o !== 1'b0) $display("FAIL fl_empty got=%b exp=0", out_valid_o); else n_pass++;
        n_checks++; if (pending_o !== 32'h0) $display("FAIL fl_pending got=%h exp=0", pending_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL fl_busy got=%b exp=0", busy_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            put(5'(i + 1), 5'(i + 2), 5'(i + 10), 1, 1, 0, 0);
            #1;
            n_checks++; if (in_ready_o !== 1'b1) $display("FAIL b2b_ready i=%0d got=%b exp=1", i, in_ready_o); else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (out_valid_o !== 1'b1 || out_rd_o !== 5'(i + 9))
                    $display("FAIL b2b_issue i=%0d got=%b/%0d exp=1/%0d", i, out_valid_o, out_rd_o, i + 9);
                else n_pass++;
            end
            step();
        end
        out_ready_i = 0;
        put(20, 21, 22, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (in_ready_o !== 1'b0) $display("FAIL b2b_backpressure got=%b exp=0", in_ready_o); else n_pass++;
            n_checks++;
            if (out_rd_o !== 5'd15 || out_rs1_o !== 5'd6 || out_rs2_o !== 5'd7)
                $display("FAIL b2b_stable got=%0d/%0d/%0d exp=15/6/7", out_rd_o, out_rs1_o, out_rs2_o);
            else n_pass++;
            step();
        end
        out_ready_i = 1;
        idle();
        step();
        n_checks++; if (out_valid_o !== 1'b0) $display("FAIL b2b_drained got=%b exp=0", out_valid_o); else n_pass++;
    endtask

    task automatic model_reset();
        m_buf.delete();
        m_pend  = '0;
        m_drain = 0;
        m_ser   = 0;
    endtask

    task automatic test_random();
        instr_t      e, ni;
        logic [31:0] after, nxt;
        int          cnt_after;
        bit          have, blocked, go, fire, exp_rdy, exp_busy;
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                idle();
                rst_i = 1;
                step();
                rst_i = 0;
                model_reset();
            end
            ni.rs1 = 5'($urandom_range(0, 7)); ni.rs2 = 5'($urandom_range(0, 7));
            ni.rd  = 5'($urandom_range(0, 7));
            ni.u1  = 1'($urandom % 2); ni.u2 = 1'($urandom % 2);
            ni.lng = ($urandom % 10) < 4; ni.ser = ($urandom % 20) == 0;
            put(ni.rs1, ni.rs2, ni.rd, ni.u1, ni.u2, ni.lng, ni.ser);
            in_valid_i    = ($urandom % 10) < 7;
            out_ready_i   = ($urandom % 10) < 8;
            wb_valid_i    = ($urandom % 10) < 4;
            wb_rd_i       = 5'($urandom_range(0, 7));
            serial_done_i = ($urandom % 5) == 0;
            flush_i       = ($urandom % 32) == 0;
            #1;

            after = m_pend;
            if (wb_valid_i && wb_rd_i != 0) after[wb_rd_i] = 1'b0;
            cnt_after = $countones(after);
            have = m_buf.size() != 0;
            if (have) e = m_buf[0];
            else e = '{default: '0};
            blocked = (e.u1 && after[e.rs1]) || (e.u2 && after[e.rs2]) ||
                      (e.lng && e.rd != 0 && after[e.rd]);
            go = have && !m_drain && !m_ser && !blocked && !flush_i &&
                 (!e.lng || cnt_after < 4) && (!e.ser || cnt_after == 0);
            fire     = go && out_ready_i;
            exp_rdy  = (!have || fire) && !flush_i;
            exp_busy = (m_pend != 0) || m_drain || m_ser;

            n_checks++; if (out_valid_o !== go) $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid_o, go); else n_pass++;
            n_checks++; if (in_ready_o !== exp_rdy) $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready_o, exp_rdy); else n_pass++;
            n_checks++; if (pending_o !== m_pend) $display("FAIL rnd_pending cyc=%0d got=%h exp=%h", cyc, pending_o, m_pend); else n_pass++;
            n_checks++; if (busy_o !== exp_busy) $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy_o, exp_busy); else n_pass++;
            if (have) begin
                n_checks++;
                if (out_rd_o !== e.rd || out_rs1_o !== e.rs1 || out_long_o !== e.lng || out_serial_o !== e.ser)
                    $display("FAIL rnd_fields cyc=%0d got=%0d/%0d/%b/%b exp=%0d/%0d/%b/%b", cyc,
                             out_rd_o, out_rs1_o, out_long_o, out_serial_o, e.rd, e.rs1, e.lng, e.ser);
                else n_pass++;
            end

            nxt = after;
            if (fire && e.lng && e.rd != 0) nxt[e.rd] = 1'b1;
            m_pend = nxt;
            if (m_ser) begin
                if (serial_done_i) m_ser = 0;
            end else if (m_drain) begin
                if (flush_i || cnt_after == 0) m_drain = 0;
            end else if (fire && e.ser) begin
                m_ser = 1;
            end else if (have && e.ser && cnt_after != 0 && !flush_i) begin
                m_drain = 1;
            end
            if (flush_i) m_buf.delete();
            else begin
                if (fire) void'(m_buf.pop_front());
                if (in_valid_i && exp_rdy) m_buf.push_back(ni);
            end
            step();
        end
        idle();
        out_ready_i = 1;
    endtask

    initial begin
        rst_i = 1;
        out_ready_i = 1;
        idle();
        test_reset();
        test_load_use();
        test_max_pending();
        test_serial();
        test_x0();
        test_flush_wb();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
